tour_sequencer: RTL
===================

TOUR_SEQUENCER -- requirements
Module: tour_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning command FIFO entries (power of two).
REQ-002 SHALL have parameter TMO_CLKS, default 50_000_000, meaning response-wait timeout in clocks.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  load-side write strobe.
REQ-006 SHALL have port wr_cmd  input  16  command word to load ({opcode[15:12], heading[11:4], squares[3:0]}).
REQ-007 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-008 SHALL have port start  input  1  begin issuing the loaded tour.
REQ-009 SHALL have port abort  input  1  stop, flush, return to IDLE.
REQ-010 SHALL have port cmd  output  16  command word presented to RemoteComm.
REQ-011 SHALL have port snd_cmd  output  1  one-cycle send pulse to RemoteComm.
REQ-012 SHALL have port cmd_snt  input  1  RemoteComm finished transmitting cmd.
REQ-013 SHALL have port resp_rdy  input  1  response byte valid (one-cycle pulse).
REQ-014 SHALL have port resp  input  8  response byte from Knight.
REQ-015 SHALL have ports busy, done, err  output  1 each  status flags; err_code  output  2; cmd_cnt  output  $clog2(DEPTH)+1  acknowledged commands.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT_SNT, WAIT_RESP, DONE, ERR.
REQ-017 IDLE: wr_en with full low SHALL push wr_cmd; wr_en with full high SHALL be ignored, FIFO unchanged; wr_en outside IDLE SHALL be ignored.
REQ-018 IDLE: start SHALL go to ISSUE next cycle if FIFO non-empty, else to DONE with cmd_cnt=0; wr_en and start in the same cycle SHALL push first, so the pushed word is included.
REQ-019 ISSUE: SHALL drive cmd = FIFO head, assert snd_cmd for exactly one cycle, go to WAIT_SNT.
REQ-020 cmd SHALL stay stable from ISSUE until the response is accepted.
REQ-021 WAIT_SNT: cmd_snt SHALL go to WAIT_RESP and clear the timeout counter; a resp_rdy in that same cycle SHALL be evaluated as the response.
REQ-022 WAIT_RESP: resp_rdy with resp==8'hA5 SHALL pop the FIFO and increment cmd_cnt; next state ISSUE if entries remain, else DONE.
REQ-023 WAIT_RESP: resp_rdy with resp!=8'hA5 SHALL go to ERR, err_code=2'b01, no pop, cmd_cnt unchanged.
REQ-024 WAIT_RESP: timeout counter SHALL increment each cycle; reaching TMO_CLKS-1 with no resp_rdy SHALL go to ERR, err_code=2'b10; resp_rdy on the terminal cycle SHALL take priority over timeout.
REQ-025 busy SHALL be high in ISSUE, WAIT_SNT, WAIT_RESP; done high only in DONE; err high only in ERR.
REQ-026 DONE and ERR SHALL hold until start (re-run from IDLE after FIFO flush; cmd_cnt cleared) or abort.
REQ-027 abort SHALL win over every other input in any state: next cycle IDLE, FIFO flushed, snd_cmd low, cmd_cnt and err_code cleared.
REQ-028 cmd_cnt SHALL saturate at DEPTH; FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-029 rst SHALL force state IDLE, FIFO empty, cmd=16'h0000, snd_cmd=0, busy=0, done=0, err=0, err_code=2'b00, cmd_cnt=0, timeout counter=0; asserted mid-operation it SHALL abandon the in-flight command with no further snd_cmd.

Structure
REQ-030 Package tour_seq_pkg SHALL hold the state enum, POS_ACK=8'hA5, and err_code constants ERR_NONE/ERR_NACK/ERR_TMO.
REQ-031 FIFO SHALL be a sub-module cmd_fifo (DEPTH x 16, synchronous push/pop/flush, full/empty).

Verification
REQ-032 Load 16'h2000, 16'h43F3; start; model acks 8'hA5 after each cmd_snt -> two snd_cmd pulses in order 2000 then 43F3, done=1, cmd_cnt=2.
REQ-033 Load 3 words; second response 8'h5A -> err=1, err_code=01, cmd_cnt=1, no third snd_cmd.
REQ-034 TMO_CLKS=1000; withhold resp_rdy -> err_code=10 exactly 1000 cycles after cmd_snt.
REQ-035 Write 9 words with DEPTH=8 -> full after 8th, 9th dropped, run issues exactly 8 commands.
REQ-036 abort during WAIT_RESP -> IDLE next cycle, busy=0, FIFO empty, late resp_rdy ignored.
REQ-037 start with empty FIFO -> done=1 next cycle, cmd_cnt=0, no snd_cmd.

Source files
------------

// File: rtl/tour_seq_pkg.sv
// Shared types and constants for the tour sequencer: FSM states, the positive
// acknowledge byte and the error codes reported on err_code.
package tour_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitSnt,
        StWaitResp,
        StDone,
        StErr
    } tour_state_e;

    localparam int unsigned CMD_W = 16;

    localparam logic [7:0] POS_ACK = 8'hA5;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_NACK = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    function automatic logic is_busy(input tour_state_e s);
        return (s == StIssue) || (s == StWaitSnt) || (s == StWaitResp);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO for the tour sequencer: synchronous push/pop/flush, head word
// presented combinationally, occupancy count alongside full/empty.
module cmd_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr_q];
    // Flush overrides any same-cycle push or pop.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/tour_sequencer.sv
// Issues a preloaded tour of 16-bit commands to RemoteComm one at a time,
// waiting for each to be sent and acknowledged, with NACK and timeout handling.
module tour_sequencer
    import tour_seq_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned TMO_CLKS = 50_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [CMD_W-1:0]       wr_cmd,
    output logic                   full,
    input  logic                   start,
    input  logic                   abort,
    output logic [CMD_W-1:0]       cmd,
    output logic                   snd_cmd,
    input  logic                   cmd_snt,
    input  logic                   resp_rdy,
    input  logic [7:0]             resp,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [$clog2(DEPTH):0] cmd_cnt
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned TW = (TMO_CLKS > 1) ? $clog2(TMO_CLKS) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CLKS - 1);

    tour_state_e      state_q, state_d;
    logic [CMD_W-1:0] cmd_q;
    logic             snd_cmd_q;
    logic             busy_q, done_q, err_q;
    logic [1:0]       err_code_q, err_code_d;
    logic [CW-1:0]    cmd_cnt_q, cmd_cnt_d;
    logic [TW-1:0]    tmo_q, tmo_d;

    logic             fifo_push, fifo_pop, fifo_flush;
    logic [CMD_W-1:0] fifo_head;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             resp_eval;
    logic             issue_now;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (wr_cmd),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        cmd_cnt_d  = cmd_cnt_q;
        tmo_d      = tmo_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        resp_eval  = 1'b0;

        unique case (state_q)
            StIdle: begin
                fifo_push = wr_en && !fifo_full;
                // A word pushed alongside start counts as part of the tour.
                if (start) begin
                    state_d = (!fifo_empty || fifo_push) ? StIssue : StDone;
                end
            end
            StIssue: begin
                state_d = StWaitSnt;
            end
            StWaitSnt: begin
                if (cmd_snt) begin
                    tmo_d     = '0;
                    state_d   = StWaitResp;
                    resp_eval = resp_rdy;
                end
            end
            StWaitResp: begin
                resp_eval = resp_rdy;
                if (!resp_rdy) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d    = StErr;
                        err_code_d = ERR_TMO;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            StDone, StErr: begin
                if (start) begin
                    state_d    = StIdle;
                    fifo_flush = 1'b1;
                    cmd_cnt_d  = '0;
                    err_code_d = ERR_NONE;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (resp_eval) begin
            if (resp == POS_ACK) begin
                fifo_pop = 1'b1;
                if (cmd_cnt_q != CW'(DEPTH)) begin
                    cmd_cnt_d = cmd_cnt_q + CW'(1);
                end
                state_d = (fifo_count > CW'(1)) ? StIssue : StDone;
            end else begin
                state_d    = StErr;
                err_code_d = ERR_NACK;
            end
        end

        if (abort) begin
            state_d    = StIdle;
            fifo_push  = 1'b0;
            fifo_pop   = 1'b0;
            fifo_flush = 1'b1;
            cmd_cnt_d  = '0;
            err_code_d = ERR_NONE;
            tmo_d      = '0;
        end
    end

    assign issue_now = (state_q == StIssue) && !abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cmd_q      <= '0;
            snd_cmd_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            cmd_cnt_q  <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            cmd_cnt_q  <= cmd_cnt_d;
            tmo_q      <= tmo_d;
            // cmd is captured only here, so it holds until the next issue.
            snd_cmd_q  <= issue_now;
            if (issue_now) begin
                cmd_q <= fifo_head;
            end
            busy_q <= is_busy(state_d);
            done_q <= (state_d == StDone);
            err_q  <= (state_d == StErr);
        end
    end

    assign full     = fifo_full;
    assign cmd      = cmd_q;
    assign snd_cmd  = snd_cmd_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign cmd_cnt  = cmd_cnt_q;

endmodule
